// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard control: load-use / RAW stall, operand forwarding select, branch flush.
// Define PIPE_HAZARD_FWD_EN to enable forwarding; otherwise hazards stall until the write-through WB.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic [3:0]        fwd_a,
  output logic [3:0]        fwd_b,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [15:0]       stall_cnt
);

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Without forwarding every producer blocks until it reaches WB (write-through register file).
  localparam int unsigned HAZ_DEPTH = FWD_EN ? LOAD_LAT : DEPTH - 1;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } entry_t;

  entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic [DEPTH-1:0]   hit_a, hit_b;
  logic               hazard;
  logic               accept;

  always_comb begin : match_logic
    hit_a  = '0;
    hit_b  = '0;
    hazard = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      hit_a[k] = id_use_rs1 && (id_rs1 != '0) && sb_q[k].v && sb_q[k].wr && (sb_q[k].rd == id_rs1);
      hit_b[k] = id_use_rs2 && (id_rs2 != '0) && sb_q[k].v && sb_q[k].wr && (sb_q[k].rd == id_rs2);
      if ((k < HAZ_DEPTH) && (sb_q[k].ld || !FWD_EN) && (hit_a[k] || hit_b[k]))
        hazard = 1'b1;
    end
  end

  assign flush  = branch_taken && sb_q[0].v;
  assign stall  = id_valid && hazard && !flush;
  assign accept = id_valid && !stall && !flush;

  // Scanning oldest to youngest lets the youngest matching producer win.
  always_comb begin : fwd_select
    fwd_a = '0;
    fwd_b = '0;
    if (FWD_EN && id_valid && !stall) begin
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (hit_a[k-1]) fwd_a = 4'(k);
        if (hit_b[k-1]) fwd_b = 4'(k);
      end
    end
  end

  always_comb begin : next_state
    sb_d = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (accept) begin
      sb_d[0].v  = 1'b1;
      sb_d[0].rd = id_rd;
      sb_d[0].wr = id_regwrite && (id_rd != '0);
      sb_d[0].ld = id_memread;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(negedge Clk or posedge reset) begin
    if (reset) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin : valid_out
    stage_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stage_valid[k] = sb_q[k].v;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (default instance plus a DEPTH=8, LOAD_LAT=7 instance).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int S_STALL  = 0;
  localparam int S_FLUSH  = 1;
  localparam int S_FWDA   = 2;
  localparam int S_FWDB   = 3;
  localparam int S_SV     = 4;
  localparam int S_CNT    = 5;
  localparam int S8_STALL = 6;
  localparam int S8_FLUSH = 7;
  localparam int S8_FWDA  = 8;
  localparam int S8_FWDB  = 9;
  localparam int S8_SV    = 10;
  localparam int S8_CNT   = 11;

  logic       Clk = 1'b1;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread, branch_taken;

  logic        stall, flush;
  logic [3:0]  fwd_a, fwd_b;
  logic [2:0]  stage_valid;
  logic [15:0] stall_cnt;

  logic        stall8, flush8;
  logic [3:0]  fwd_a8, fwd_b8;
  logic [7:0]  stage_valid8;
  logic [15:0] stall_cnt8;

  int checks   = 0;
  int failures = 0;

  int          sig_q[$];
  logic [15:0] exp_q[$];
  string       tag_q[$];

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl dut (
    .Clk(Clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(8), .LOAD_LAT(7)) dut8 (
    .Clk(Clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .stall(stall8), .flush(flush8), .fwd_a(fwd_a8), .fwd_b(fwd_b8),
    .stage_valid(stage_valid8), .stall_cnt(stall_cnt8)
  );

  function automatic logic [15:0] observe(input int s);
    case (s)
      S_STALL:  return {15'd0, stall};
      S_FLUSH:  return {15'd0, flush};
      S_FWDA:   return {12'd0, fwd_a};
      S_FWDB:   return {12'd0, fwd_b};
      S_SV:     return {13'd0, stage_valid};
      S_CNT:    return stall_cnt;
      S8_STALL: return {15'd0, stall8};
      S8_FLUSH: return {15'd0, flush8};
      S8_FWDA:  return {12'd0, fwd_a8};
      S8_FWDB:  return {12'd0, fwd_b8};
      S8_SV:    return {8'd0, stage_valid8};
      S8_CNT:   return stall_cnt8;
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic push_exp(input int s, input logic [15:0] v, input string tag);
    sig_q.push_back(s);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_pending();
    int          s;
    logic [15:0] e, obs;
    string       tag;
    while (sig_q.size() != 0) begin
      s   = sig_q.pop_front();
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = observe(s);
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic sample();
    #2;
    check_pending();
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
    id_valid    = v;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    branch_taken = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      idle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t limit=%0t", $time, 1_000_000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge Clk);
    push_exp(S_STALL, 16'd0, "rst_stall");
    push_exp(S_FLUSH, 16'd0, "rst_flush");
    push_exp(S_FWDA,  16'd0, "rst_fwd_a");
    push_exp(S_FWDB,  16'd0, "rst_fwd_b");
    push_exp(S_SV,    16'd0, "rst_stage_valid");
    push_exp(S_CNT,   16'd0, "rst_stall_cnt");
    push_exp(S8_SV,   16'd0, "rst_stage_valid8");
    push_exp(S8_CNT,  16'd0, "rst_stall_cnt8");
    sample();
    reset = 1'b0;

    // add x5 then consumer of x5
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    push_exp(S_STALL, 16'd0, "a1_stall");
    sample();
    @(posedge Clk); set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    push_exp(S_SV,    16'd1, "a2_stage_valid");
    push_exp(S_STALL, FWD ? 16'd0 : 16'd1, "a2_stall");
    push_exp(S_FWDA,  FWD ? 16'd1 : 16'd0, "a2_fwd_a");
    sample();
    @(posedge Clk);
    push_exp(S_SV,    FWD ? 16'd3 : 16'd2, "a3_stage_valid");
    push_exp(S_STALL, FWD ? 16'd0 : 16'd1, "a3_stall");
    push_exp(S_FWDA,  FWD ? 16'd2 : 16'd0, "a3_fwd_a");
    sample();
    @(posedge Clk);
    push_exp(S_SV,    FWD ? 16'd7 : 16'd4, "a4_stage_valid");
    push_exp(S_STALL, 16'd0, "a4_stall");
    push_exp(S_FWDA,  FWD ? 16'd3 : 16'd0, "a4_fwd_a");
    push_exp(S_CNT,   FWD ? 16'd0 : 16'd2, "a4_stall_cnt");
    sample();
    @(posedge Clk); set_id(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    push_exp(S_STALL, 16'd0, "a5_invalid_stall");
    push_exp(S_FWDA,  16'd0, "a5_invalid_fwd_a");
    sample();
    drain(2);

    // load-use on rs2
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    push_exp(S_STALL, 16'd0, "b1_stall");
    sample();
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    push_exp(S_STALL, 16'd1, "b2_stall");
    push_exp(S_FWDB,  16'd0, "b2_fwd_b");
    sample();
    @(posedge Clk);
    push_exp(S_STALL, FWD ? 16'd0 : 16'd1, "b3_stall");
    push_exp(S_FWDB,  FWD ? 16'd2 : 16'd0, "b3_fwd_b");
    push_exp(S_CNT,   FWD ? 16'd1 : 16'd3, "b3_stall_cnt");
    sample();
    @(posedge Clk); idle();
    push_exp(S_CNT,   FWD ? 16'd1 : 16'd4, "b4_stall_cnt");
    sample();
    drain(2);

    // taken branch during a load-use stall
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    push_exp(S_FLUSH, 16'd0, "c1_flush");
    sample();
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    branch_taken = 1'b1;
    push_exp(S_FLUSH, 16'd1, "c2_flush");
    push_exp(S_STALL, 16'd0, "c2_stall");
    sample();
    @(posedge Clk); idle(); branch_taken = 1'b1;
    push_exp(S_FLUSH, 16'd0, "c3_flush_on_bubble");
    push_exp(S_SV,    16'd2, "c3_stage_valid");
    push_exp(S_CNT,   FWD ? 16'd1 : 16'd4, "c3_stall_cnt");
    sample();
    drain(2);

    // x0 producer is never hazardous
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    push_exp(S_SV,    16'd1, "d2_stage_valid");
    push_exp(S_STALL, 16'd0, "d2_x0_stall");
    push_exp(S_FWDA,  16'd0, "d2_x0_fwd_a");
    push_exp(S_FWDB,  16'd0, "d2_x0_fwd_b");
    sample();
    drain(3);

    // reset mid-stall
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    @(posedge Clk); set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    push_exp(S_STALL, 16'd1, "e2_stall");
    sample();
    reset = 1'b1;
    #1;
    push_exp(S_STALL, 16'd0, "e_rst_stall");
    push_exp(S_SV,    16'd0, "e_rst_stage_valid");
    push_exp(S_CNT,   16'd0, "e_rst_stall_cnt");
    push_exp(S8_CNT,  16'd0, "e_rst_stall_cnt8");
    check_pending();
    reset = 1'b0;
    @(posedge Clk); idle();
    push_exp(S_SV,    16'd1, "e3_accept_after_rst");
    push_exp(S_CNT,   16'd0, "e3_stall_cnt");
    sample();
    drain(10);
    @(posedge Clk);
    #3 reset = 1'b1;
    #1 reset = 1'b0;

    // deep instance: self-dependent load repeats 7 stalls per 8 cycles until the counter saturates
    @(posedge Clk); set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    for (int t = 0; t <= 74910; t++) begin
      if (t != 0) @(posedge Clk);
      if (t == 0) push_exp(S8_STALL, 16'd0, "f0_stall8");
      if (t == 1) begin
        push_exp(S8_STALL, 16'd1, "f1_stall8");
        push_exp(S8_FWDA,  16'd0, "f1_fwd_a8");
        push_exp(S8_FLUSH, 16'd0, "f1_flush8");
        push_exp(S8_FWDB,  16'd0, "f1_fwd_b8");
      end
      if (t == 7) push_exp(S8_STALL, 16'd1, "f7_stall8");
      if (t == 8) begin
        push_exp(S8_STALL, 16'd0, "f8_stall8");
        push_exp(S8_FWDA,  FWD ? 16'd8 : 16'd0, "f8_fwd_a8");
        push_exp(S8_CNT,   16'd7, "f8_stall_cnt8");
        push_exp(S8_SV,    16'h0080, "f8_stage_valid8");
      end
      if (t == 8 * 9362) push_exp(S8_CNT, 16'hFFFE, "f_cnt_below_sat");
      if (t == 8 * 9363) push_exp(S8_CNT, 16'hFFFF, "f_cnt_sat");
      if (t == 74910)    push_exp(S8_CNT, 16'hFFFF, "f_cnt_sat_hold");
      sample();
    end
    #1 reset = 1'b1;
    #1;
    push_exp(S8_CNT,   16'd0, "g_rst_stall_cnt8");
    push_exp(S8_SV,    16'd0, "g_rst_stage_valid8");
    push_exp(S8_STALL, 16'd0, "g_rst_stall8");
    check_pending();
    reset = 1'b0;
    @(posedge Clk);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning tracked stages after decode (1 = EX ... DEPTH = WB); legal range 2..8.
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning stages after EX before a load result can be forwarded; legal range 1..DEPTH-1.
REQ-004 SHALL have port Clk  in  1  clock; all state updates on the falling edge, as the rest of the pipeline does.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port id_valid  in  1  decode stage holds a valid instruction.
REQ-007 SHALL have ports id_rs1, id_rs2  in  REG_AW  decode source registers.
REQ-008 SHALL have ports id_use_rs1, id_use_rs2  in  1  the source is actually read.
REQ-009 SHALL have port id_rd  in  REG_AW  decode destination register.
REQ-010 SHALL have port id_regwrite  in  1  decode instruction writes rd.
REQ-011 SHALL have port id_memread  in  1  decode instruction is a load.
REQ-012 SHALL have port branch_taken  in  1  branch in EX resolved taken.
REQ-013 SHALL have port stall  out  1  hold PC and IF/ID and insert a bubble into EX (combinational).
REQ-014 SHALL have port flush  out  1  kill IF/ID contents (combinational).
REQ-015 SHALL have ports fwd_a, fwd_b  out  4  operand source: 0 = register file, k = stage-k result (combinational).
REQ-016 SHALL have port stage_valid  out  DEPTH  bit k-1 = stage k holds a non-bubble.
REQ-017 SHALL have port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 SHALL keep a scoreboard entry per stage k = 1..DEPTH: {v, rd, wr, ld}, where wr = regwrite and rd != 0.
REQ-019 SHALL shift entries each falling edge: S[k+1] <= S[k]; S[DEPTH] is discarded.
REQ-020 SHALL load S[1] with {1, id_rd, id_regwrite and id_rd != 0, id_memread} when id_valid and not stall and not flush; otherwise S[1] SHALL become a bubble (all zero).
REQ-021 SHALL assert flush = branch_taken and S[1].v; the EX branch itself SHALL continue to advance.
REQ-022 SHALL give flush priority: when flush = 1, stall SHALL be 0 and stall_cnt SHALL not increment.
REQ-023 A source SHALL match stage k when it is used, is nonzero, equals S[k].rd, and S[k].v and S[k].wr are both 1.
REQ-024 SHALL compute fwd_x as the smallest matching k (youngest producer wins), else 0; fwd_x SHALL be 0 whenever stall = 1.
REQ-025 SHALL assert stall when id_valid and either source matches a stage k <= LOAD_LAT with S[k].ld = 1.
REQ-026 A load with LOAD_LAT = L SHALL produce exactly L consecutive stall cycles for an immediately dependent instruction, then forward from stage L+1.
REQ-027 SHALL treat x0 as never hazardous and never forwarded.
REQ-028 stall_cnt SHALL increment by 1 per falling edge with stall = 1 and hold at 16'hFFFF.
REQ-029 With id_valid = 0, stall, fwd_a and fwd_b SHALL be 0.

Reset
REQ-030 reset SHALL asynchronously clear all scoreboard entries, stage_valid and stall_cnt to 0; stall, flush, fwd_a and fwd_b SHALL then evaluate to 0.
REQ-031 reset asserted mid-stall SHALL end the stall immediately, and the first edge after deassertion SHALL accept the decode instruction.

Configuration
REQ-032 Macro PIPE_HAZARD_FWD_EN defined SHALL give the forwarding behaviour of REQ-024 to REQ-026.
REQ-033 Macro PIPE_HAZARD_FWD_EN undefined SHALL force fwd_a and fwd_b to 0, and stall SHALL assert on any source match in stages 1..DEPTH-1, because the register file is write-through in WB.

Verification
REQ-034 Defaults; add x5 then add rs1 = x5 back-to-back -> stall 0, fwd_a = 1.
REQ-035 Defaults; ld x6 then add rs2 = x6 -> one stall cycle, then fwd_b = 2, stall_cnt = 1.
REQ-036 LOAD_LAT = 2, DEPTH = 4; ld x7 then use x7 -> two stall cycles, then fwd_a = 3.
REQ-037 branch_taken with S[1].v = 1 during a load-use stall -> flush 1, stall 0, S[1] bubble next edge, stall_cnt unchanged.
REQ-038 Producer rd = x0 followed by a consumer of x0 -> no stall, fwd 0; with PIPE_HAZARD_FWD_EN undefined, add x5 then use x5 -> stall for DEPTH-1 = 2 cycles.
REQ-039 Force 65540 stall cycles -> stall_cnt = 16'hFFFF; pulse reset -> stall_cnt 0 and stage_valid 0 with no clock edge.
